// File: rtl/div_seq_pkg.sv
// div_seq_pkg: FSM states and special-case constants shared by the sequential divider
package div_seq_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t;
  localparam logic [31:0] DIV_ZERO_Q       = 32'hFFFF_FFFF;
  localparam logic [31:0] DIV_OVF_DIVIDEND = 32'h8000_0000;
endpackage

// File: rtl/div_seq_step.sv
// div_step: one restoring-division iteration on an XLEN-bit remainder/quotient pair
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);
  logic [XLEN:0] sh, trial;
  assign sh    = {rem_i, quo_i[XLEN-1]};
  assign trial = sh - {1'b0, dvs_i};
  assign rem_o = trial[XLEN] ? sh[XLEN-1:0] : trial[XLEN-1:0];
  assign quo_o = {quo_i[XLEN-2:0], ~trial[XLEN]};
endmodule

// File: rtl/div_seq.sv
// div_seq: multi-cycle RV32M DIV/DIVU/REM/REMU sequencer holding the pipeline until the result is ready
module div_seq
  import div_seq_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            is_signed,
  input  logic            want_rem,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int STEPS = XLEN / BITS_PER_CYCLE;
  localparam int CW    = $clog2(STEPS + 1);
  div_state_t state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, res_q, res_d;
  logic            qneg_q, qneg_d, rneg_q, rneg_d, wrem_q, wrem_d;
  logic [XLEN-1:0] rem_c [BITS_PER_CYCLE+1];
  logic [XLEN-1:0] quo_c [BITS_PER_CYCLE+1];
  logic            dd_neg, dvs_neg, dvs_zero, ovf;
  logic [XLEN-1:0] dd_abs, dvs_abs, q_fix, r_fix;
  assign rem_c[0] = rem_q;
  assign quo_c[0] = quo_q;
  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
    div_step #(.XLEN(XLEN)) u_step (
      .rem_i(rem_c[i]),
      .quo_i(quo_c[i]),
      .dvs_i(dvs_q),
      .rem_o(rem_c[i+1]),
      .quo_o(quo_c[i+1])
    );
  end
  assign dd_neg   = is_signed && dividend[XLEN-1];
  assign dvs_neg  = is_signed && divisor[XLEN-1];
  assign dd_abs   = dd_neg ? -dividend : dividend;
  assign dvs_abs  = dvs_neg ? -divisor : divisor;
  assign dvs_zero = divisor == '0;
  assign ovf      = is_signed && dividend == XLEN'(DIV_OVF_DIVIDEND) && divisor == '1;
  assign q_fix    = qneg_q ? -quo_q : quo_q;
  assign r_fix    = rneg_q ? -rem_q : rem_q;
  // a flush drops stall in the same cycle so the redirect is not held off
  assign stall  = !flush && (state_q == IDLE ? start : (state_q == CALC || state_q == FIX));
  assign busy   = state_q != IDLE;
  assign done   = state_q == DONE && !flush;
  assign result = res_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    res_d   = res_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    wrem_d  = wrem_q;
    if (flush) begin
      state_d = IDLE;
    end else if (state_q == IDLE && start) begin
      wrem_d  = want_rem;
      qneg_d  = dd_neg ^ dvs_neg;
      rneg_d  = dd_neg;
      quo_d   = dd_abs;
      dvs_d   = dvs_abs;
      rem_d   = '0;
      cnt_d   = CW'(STEPS);
      state_d = (dvs_zero || ovf) ? DONE : CALC;
      res_d   = dvs_zero ? (want_rem ? dividend : XLEN'(DIV_ZERO_Q)) :
                ovf      ? (want_rem ? '0 : XLEN'(DIV_OVF_DIVIDEND)) : res_q;
    end else if (state_q == CALC) begin
      rem_d   = rem_c[BITS_PER_CYCLE];
      quo_d   = quo_c[BITS_PER_CYCLE];
      cnt_d   = cnt_q - 1'b1;
      state_d = cnt_q == CW'(1) ? FIX : CALC;
    end else if (state_q == FIX) begin
      res_d   = wrem_q ? r_fix : q_fix;
      state_d = DONE;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      res_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      wrem_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      res_q   <= res_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      wrem_q  <= wrem_d;
    end
  end
endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
Multi-cycle sequencer for RV32M DIV/DIVU/REM/REMU in the EX stage. It replaces edge-triggered divide-stall counting with a synchronous FSM and an iterative restoring divider. It accepts an operation from ID/EX and holds the pipeline via `stall` until the result is ready. It then presents the result for exactly one cycle so EX/DM captures it.

Parameters:
- XLEN, 32, operand/result width.
- BITS_PER_CYCLE, 1, quotient bits retired per CALC cycle. Legal values are 1, 2 and 4; XLEN must be a multiple of it.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  a divide op is in EX. Held high by the pipeline while `stall` is high.
- is_signed  in  1  1 = DIV/REM, 0 = DIVU/REMU. Sampled on acceptance.
- want_rem  in  1  1 = REM/REMU, 0 = DIV/DIVU. Sampled on acceptance.
- dividend  in  XLEN  src0_EX. Sampled on acceptance.
- divisor  in  XLEN  src1_EX. Sampled on acceptance.
- flush  in  1  abort the current op (flow change or ecall).
- stall  out  1  freeze PC, IF/ID and ID/EX.
- busy  out  1  FSM not in IDLE.
- done  out  1  result valid this cycle.
- result  out  XLEN  quotient or remainder.

Behaviour:
- Reset: state=IDLE, stall=0, busy=0, done=0, result=0, internal count/regs=0. Asynchronous assert; takes effect mid-operation with no completion.
- States: IDLE, CALC, FIX, DONE.
- Acceptance happens when state==IDLE && start && !flush. On acceptance:
  - latch op bits;
  - take absolute values when is_signed;
  - record quotient sign = sign(dividend) XOR sign(divisor) and remainder sign = sign(dividend);
  - count = XLEN/BITS_PER_CYCLE;
  - next state = CALC, or DONE for special cases.
- stall (combinational) = (IDLE && start && !flush) || CALC || FIX. It is 0 in DONE.
- Special cases go IDLE -> DONE directly, giving 1 stall cycle:
  - divisor==0: quotient = all ones; remainder = dividend. Applies to signed and unsigned.
  - signed, dividend==0x80000000 and divisor==0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- CALC: each cycle performs BITS_PER_CYCLE restoring steps. Each step:
  - shift {rem,quo} left by 1;
  - trial = rem - divisor on XLEN+1 bits;
  - if trial is non-negative, rem = trial and quo[0] = 1.
  - count decrements; at count==1 the next state is FIX.
- FIX: applies the 2's-complement sign correction to quo/rem, selects via want_rem, registers result; next state = DONE.
- DONE: done=1 and result valid for exactly one cycle; start is ignored; next state = IDLE.
- Normal latency: accept cycle + XLEN/BITS_PER_CYCLE CALC + 1 FIX gives 34 stall cycles for 32/1, then done. A back-to-back divide is accepted the cycle after DONE.
- result holds its value after DONE until the next FIX or special-case load.
- flush in any state: next state = IDLE, done is not asserted, and stall drops combinationally that cycle. A flush together with start in IDLE means the op is not accepted.
- Signed mode applies to both DIV and REM. Unsigned ops never negate.

Decomposition:
- The shared package (common) gains:
  - typedef enum `div_state_t` {IDLE, CALC, FIX, DONE};
  - constants `DIV_ZERO_Q` = all ones and `DIV_OVF_DIVIDEND` = 0x80000000.
- One natural sub-module, `div_step`: combinational, a single restoring iteration (rem, quo, divisor in; rem, quo out). It is instantiated BITS_PER_CYCLE times in a chain.
- div_seq holds the FSM, counter, sign handling and special-case detection.

Test Plan:
- DIVU 100/7, start held -> stall high for 34 cycles; then done=1 for one cycle with result=14; stall=0 that cycle. REMU with the same operands -> result=2.
- DIV -7/2 -> result=0xFFFFFFFD (-3). REM -7/2 -> result=0xFFFFFFFF (-1). Remainder sign follows the dividend.
- DIV 0x80000000/0xFFFFFFFF -> 1 stall cycle, done next, result=0x80000000. REM with the same operands -> result=0.
- DIVU 5/0 -> result=0xFFFFFFFF after 1 stall cycle. REM 5/0 -> result=5.
- flush asserted at CALC cycle 10 -> IDLE next cycle; stall=0 in the flush cycle; done never asserted. A new DIVU 9/3 is accepted afterwards and gives 3.
- rst pulsed during CALC -> all outputs 0 immediately. Also, with BITS_PER_CYCLE=4, DIVU 0xFFFFFFFF/1 -> 10 stall cycles, then result=0xFFFFFFFF.
